svn_scan_drv: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Holds a shadow copy of the packed hex digits, decimal points and blanking mask, and scans one digit per slot.
- Drives active-low segment and anode lines, with anti-ghosting guard cycles.
- Sits between the datapath (counters, registers under display) and the board display pins.

---
 rtl/svn_pkg.sv | 32 +++
 rtl/svn_scan_drv_if.sv | 27 ++
 rtl/svn_prescaler.sv | 27 ++
 rtl/svn_scan_drv.sv | 135 +++++++++++++
 tb/tb_svn_scan_drv.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/svn_pkg.sv
// Shared constants and the hex-to-glyph decoder for the 7-segment scan driver.
package svn_pkg;

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low common-anode glyphs, bit order {a,b,c,d,e,f,g}
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    unique case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/svn_scan_drv_if.sv
// Datapath-facing inputs and board-facing display pins of the scan driver.
interface svn_scan_drv_if
  import svn_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic                      en;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank;
  logic [SEG_W-1:0]          seg;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output en, digits, dp_in, blank,
    input  seg, dp_n, an, frame_done
  );

  modport slave (
    input  en, digits, dp_in, blank,
    output seg, dp_n, an, frame_done
  );

endinterface

// File: rtl/svn_prescaler.sv
// Slot prescaler: counts 0..DIV_CNT-1 with synchronous clear and a wrap tick.
module svn_prescaler #(
  parameter  int unsigned DIV_CNT = 100000,
  localparam int unsigned CNT_W   = $clog2(DIV_CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CNT - 1);

  assign tick_c = !clr && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/svn_scan_drv.sv
// Time-multiplexed common-anode 7-segment driver with per-frame shadow and guard cycles.
// Optional leading-zero blanking: define SVN_LEADING_ZERO_BLANK_EN.
module svn_scan_drv
  import svn_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV_CNT    = 100000,
  parameter int unsigned GUARD      = 2
) (
  input logic           clk,
  input logic           rst_n,
  svn_scan_drv_if.slave bus
);

  localparam int unsigned      IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned      CNT_W     = $clog2(DIV_CNT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);

  logic [CNT_W-1:0]        cnt;
  logic                    tick_c;
  logic                    wrap_c;
  logic [IDX_W-1:0]        idx;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   eff_blank_c;

  logic [3:0]              cur_nib_c;
  logic                    cur_dp_c;
  logic                    cur_blank_c;
  logic [NUM_DIGITS-1:0]   an_sel_c;
  logic                    guard_c;

  logic [SEG_W-1:0]        seg_q;
  logic                    dp_n_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    frame_done_q;

  svn_prescaler #(
    .DIV_CNT (DIV_CNT)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!bus.en),
    .cnt    (cnt),
    .tick_c (tick_c)
  );

  assign wrap_c  = tick_c && (idx == IDX_LAST);
  assign guard_c = (cnt < GUARD_END);

  // Digit index and shadow; shadow tracks inputs while idle and reloads only at frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
    end else begin
      if (!bus.en) begin
        idx <= '0;
      end else if (tick_c) begin
        idx <= wrap_c ? '0 : idx + IDX_W'(1);
      end
      if (!bus.en || wrap_c) begin
        sh_digits <= bus.digits;
        sh_dp     <= bus.dp_in;
        sh_blank  <= bus.blank;
      end
    end
  end

`ifdef SVN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_c;

  // Digit i>0 goes dark when it and every more-significant shadow nibble is zero
  always_comb begin : lz_mask
    logic zero_above;
    zero_above = 1'b1;
    lz_c       = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_above = zero_above && (sh_digits[4*i +: 4] == 4'h0);
      lz_c[i]    = zero_above;
    end
  end

  assign eff_blank_c = sh_blank | lz_c;
`else
  assign eff_blank_c = sh_blank;
`endif

  always_comb begin : digit_mux
    cur_nib_c   = 4'h0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    an_sel_c    = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib_c   = sh_digits[4*i +: 4];
        cur_dp_c    = sh_dp[i];
        cur_blank_c = eff_blank_c[i];
        an_sel_c[i] = 1'b0;
      end
    end
  end

  // Pin registers: one cycle behind idx/cnt, dark whenever the scan is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap_c;
      if (!bus.en) begin
        an_q   <= '1;
        seg_q  <= SEG_OFF;
        dp_n_q <= 1'b1;
      end else begin
        an_q   <= guard_c ? '1 : an_sel_c;
        seg_q  <= cur_blank_c ? SEG_OFF : hex_to_seg(cur_nib_c);
        dp_n_q <= !cur_dp_c;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_svn_scan_drv.sv
// Scoreboard bench for svn_scan_drv (4 digits, 4-cycle slots, 1 guard cycle).
module tb_svn_scan_drv;

  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned GRD = 1;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic [3:0]  eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vecs[$];

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  svn_scan_drv_if #(.NUM_DIGITS(ND)) bus ();

  svn_scan_drv #(
    .NUM_DIGITS (ND),
    .DIV_CNT    (DIV),
    .GUARD      (GRD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output cycle that has an expectation is compared at the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL missed cyc=%0d: expectation never sampled", e.cyc);
      end else if ({bus.an, bus.seg, bus.dp_n, bus.frame_done} !== {e.an, e.seg, e.dp_n, e.fd}) begin
        n_bad++;
        $display("FAIL pins cyc=%0d: got an=%b seg=%b dp_n=%b fd=%b, need an=%b seg=%b dp_n=%b fd=%b",
                 cyc, bus.an, bus.seg, bus.dp_n, bus.frame_done, e.an, e.seg, e.dp_n, e.fd);
      end
    end
  end

  task automatic push_frame(input int base, input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] eb, input int n);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (4*k + j < n) begin
          e.cyc  = base + 4*k + j;
          e.an   = (j < int'(GRD)) ? 4'hF : ~(4'b0001 << k);
          e.seg  = eb[k] ? 7'h7F : glyph[d[4*k +: 4]];
          e.dp_n = ~dp[k];
          e.fd   = (k == 3 && j == 3);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic push_dark(input int c);
    exp_t e;
    e.cyc = c; e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1; e.fd = 1'b0;
    sb.push_back(e);
  endtask

  task automatic check_now(input string name);
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp_n, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s: got an=%b seg=%b dp_n=%b fd=%b, need an=1111 seg=1111111 dp_n=1 fd=0",
               name, bus.an, bus.seg, bus.dp_n, bus.frame_done);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input vec_t v);
    bus.digits = v.d;
    bus.dp_in  = v.dp;
    bus.blank  = v.bl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t cur;
    vec_t fresh;
    vec_t v;
    logic [3:0] zero_eb;
    int base;
    int cr;

    vecs.push_back('{16'hABCD, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{16'hABCD, 4'b0100, 4'b0100, 4'b0100});
    for (int n = 0; n < 16; n++) begin
      v.d = 16'h5670 + 16'(n); v.dp = 4'b1000; v.bl = 4'b0000; v.eb = 4'b0000;
      vecs.push_back(v);
    end
`ifdef SVN_LEADING_ZERO_BLANK_EN
    vecs.push_back('{16'h0040, 4'b0000, 4'b0000, 4'b1100});
    vecs.push_back('{16'h0000, 4'b0000, 4'b0000, 4'b1110});
    zero_eb = 4'b1110;
`else
    zero_eb = 4'b0000;
`endif
    vecs.push_back('{16'h1234, 4'b0000, 4'b0000, 4'b0000});
    fresh = '{16'h9E07, 4'b0010, 4'b1000, 4'b1000};

    rst_n      = 1'b1;
    bus.en     = 1'b0;
    cur        = '{16'h1234, 4'b0000, 4'b0000, 4'b0000};
    apply(cur);
    #1 rst_n = 1'b0;
    #22;
    check_now("reset_state");
    push_dark(3);
    rst_n = 1'b1;

    // Idle cycle loads the shadow; scan starts on the first enabled cycle
    wait_cyc(3);
    bus.en = 1'b1;
    base = 4;
    foreach (vecs[f]) begin
      push_frame(base, cur.d, cur.dp, cur.eb, 16);
      wait_cyc(base + 5);
      apply(vecs[f]);
      cur = vecs[f];
      base += 16;
    end

    // Disable mid-frame, then restart from digit 0 with new inputs
    push_frame(base, cur.d, cur.dp, cur.eb, 7);
    wait_cyc(base + 6);
    bus.en = 1'b0;
    apply(fresh);
    for (int c = 7; c <= 9; c++) push_dark(base + c);
    wait_cyc(base + 9);
    bus.en = 1'b1;
    base += 10;
    push_frame(base, fresh.d, fresh.dp, fresh.eb, 6);

    // Asynchronous reset mid-slot, then a frame from the cleared shadow
    wait_cyc(base + 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cr = cyc;
    push_frame(cr + 1, 16'h0000, 4'b0000, zero_eb, 16);
    wait_cyc(cr + 17);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL leftover cyc=%0d: expectation not reached", e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
